// File: rtl/rand_range_if.sv
// CPU-side request/response bundle for rand_range_unit.
// The master (CPU) drives the request and acknowledge. The slave (the unit) returns the status
// and the bounded result.
interface rand_range_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req;
   logic [WIDTH-1:0] bound;
   logic             busy;
   logic             out_valid;
   logic             out_ack;
   logic [WIDTH-1:0] result;

   modport master (
      output req,
      output bound,
      output out_ack,
      input  busy,
      input  out_valid,
      input  result
   );

   modport slave (
      input  req,
      input  bound,
      input  out_ack,
      output busy,
      output out_valid,
      output result
   );
endinterface

// File: rtl/rand_range_unit.sv
// rand_range_unit: draws one sample from an LFSR per request and reduces it into [0, bound).
// It uses a WIDTH-step restoring remainder. A bound of 0 returns the raw sample unchanged.
module rand_range_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   rand_range_if.slave      cpu,
   input  logic [WIDTH-1:0] rand_in,
   output logic             rand_next
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StSample, StDivide, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] bound_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH:0]   rem_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             busy_q;
   logic             out_valid_q;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   rem_step;
   logic             take;
   logic             last_iter;

   // One restoring-remainder step: shift in the next dividend bit, subtract bound if it fits.
   // rem_q[WIDTH] is always 0 because rem < bound. It still forces a subtract, so the bit is not left dangling.
   always_comb begin
      trial     = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
      take      = rem_q[WIDTH] | (trial >= {1'b0, bound_q});
      rem_step  = take ? (trial - {1'b0, bound_q}) : trial;
      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

   // Control FSM and datapath: all state and registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= StIdle;
         bound_q     <= '0;
         dividend_q  <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cpu.req) begin
                  bound_q <= cpu.bound;
                  busy_q  <= 1'b1;
                  state_q <= StSample;
               end
            end
            StSample: begin
               // rand_in still holds the pre-advance value at this edge.
               dividend_q <= rand_in;
               rem_q      <= '0;
               cnt_q      <= '0;
               if (bound_q == '0) begin
                  result_q    <= rand_in;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  state_q <= StDivide;
               end
            end
            StDivide: begin
               rem_q      <= rem_step;
               dividend_q <= dividend_q << 1;
               cnt_q      <= cnt_q + CW'(1);
               if (last_iter) begin
                  result_q    <= rem_step[WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               // req in this state is ignored, even together with out_ack.
               if (cpu.out_ack) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // LFSR advance is a pure decode of the one-cycle SAMPLE state.
   always_comb begin
      rand_next = (state_q == StSample);
   end

   assign cpu.busy      = busy_q;
   assign cpu.out_valid = out_valid_q;
   assign cpu.result    = result_q;

endmodule

// File: tb/tb_rand_range_unit.sv
// Scoreboard bench for rand_range_unit.
// Stimulus pushes the expected remainder and latency for each request. A monitor pops an entry
// on each rising out_valid and checks it.
module tb_rand_range_unit;

   localparam int unsigned WIDTH = 32;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] rand_in;
   logic        rand_next;

   rand_range_if #(.WIDTH(WIDTH)) cpu ();

   rand_range_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .cpu       (cpu),
      .rand_in   (rand_in),
      .rand_next (rand_next)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      int          latency;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycle       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, want);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Monitor: samples on the falling edge and pops an expectation on each new result.
   task automatic monitor();
      logic pv  = 1'b0;
      logic pb  = 1'b0;
      logic prn = 1'b0;
      int   start = 0;
      int   rn    = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cycle++;
         if (!clr_n) begin
            pv  = 1'b0;
            pb  = 1'b0;
            prn = 1'b0;
         end else begin
            if (rand_next && prn) begin
               miscompares++;
               $display("FAIL rand_next_consecutive: got two high cycles, expected single pulse");
            end
            if (cpu.busy && !pb) begin
               start = cycle;
               rn    = 0;
            end
            if (rand_next) rn++;
            if (cpu.out_valid && !pv) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_result: got 0x%08h, expected no result", cpu.result);
               end else begin
                  e = exp_q.pop_front();
                  check("result", cpu.result, e.result);
                  check("latency", cycle - start + 1, e.latency);
                  check("rand_next_pulses", rn, 1);
               end
            end
            pv  = cpu.out_valid;
            pb  = cpu.busy;
            prn = rand_next;
         end
      end
   endtask

   // One full transaction; expected value from plain modular arithmetic.
   task automatic do_op(input logic [31:0] b, input logic [31:0] r, input int hold,
                        input bit scramble, input bit req_with_ack);
      exp_t        e;
      logic [31:0] want;
      int          waited;
      want      = (b == 0) ? r : (r % b);
      e.result  = want;
      e.latency = (b == 0) ? 2 : 34;
      @(negedge clk);
      check_bit("idle_before_req", cpu.busy, 1'b0);
      cpu.req   = 1'b1;
      cpu.bound = b;
      rand_in   = r;
      exp_q.push_back(e);
      @(negedge clk);
      cpu.req = 1'b0;
      if (scramble) cpu.bound = $urandom;
      waited = 0;
      while (!cpu.out_valid && waited < 60) begin
         @(negedge clk);
         waited++;
         if (scramble) begin
            cpu.bound = $urandom;
            rand_in   = $urandom;
         end
      end
      if (!cpu.out_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL result_timeout: got no out_valid in 60 cycles, expected out_valid");
         finish_run();
      end
      for (int i = 0; i < hold; i++) begin
         check_bit("valid_held", cpu.out_valid, 1'b1);
         check("result_held", cpu.result, want);
         @(negedge clk);
         if (scramble) begin
            cpu.bound = $urandom;
            rand_in   = $urandom;
         end
      end
      check_bit("valid_before_ack", cpu.out_valid, 1'b1);
      cpu.out_ack = 1'b1;
      if (req_with_ack) cpu.req = 1'b1;
      @(negedge clk);
      cpu.out_ack = 1'b0;
      cpu.req     = 1'b0;
      check_bit("idle_after_ack", cpu.busy, 1'b0);
      check_bit("valid_after_ack", cpu.out_valid, 1'b0);
      check("result_kept", cpu.result, want);
      if (req_with_ack) begin
         @(negedge clk);
         check_bit("req_with_ack_ignored", cpu.busy, 1'b0);
      end
   endtask

   task automatic stimulus();
      logic [31:0] b;
      int          sel;
      #1;
      check_bit("reset_busy", cpu.busy, 1'b0);
      check_bit("reset_valid", cpu.out_valid, 1'b0);
      check_bit("reset_rand_next", rand_next, 1'b0);
      check("reset_result", cpu.result, 32'h0);
      repeat (3) @(negedge clk);
      clr_n = 1'b1;

      do_op(32'd10, 32'h0000_0457, 0, 1'b0, 1'b0);
      do_op(32'd0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
      do_op(32'd7, 32'h8000_0000, 0, 1'b0, 1'b0);
      do_op(32'd1, $urandom, 0, 1'b0, 1'b0);
      do_op(32'd13, $urandom, 5, 1'b0, 1'b1);
      do_op(32'd3, 32'd100, 0, 1'b0, 1'b0);
      do_op(32'd12345, $urandom, 2, 1'b1, 1'b0);

      // Abandon an operation midway through the divide with an asynchronous reset pulse.
      @(negedge clk);
      cpu.req   = 1'b1;
      cpu.bound = 32'd10;
      rand_in   = 32'd1111;
      @(posedge clk);
      #1 cpu.req = 1'b0;
      repeat (16) @(posedge clk);
      #2 clr_n = 1'b0;
      #1;
      check_bit("midreset_busy", cpu.busy, 1'b0);
      check_bit("midreset_valid", cpu.out_valid, 1'b0);
      check_bit("midreset_rand_next", rand_next, 1'b0);
      check("midreset_result", cpu.result, 32'h0);
      #1 clr_n = 1'b1;
      do_op(32'd10, 32'd1111, 0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 20);
            2:       b = $urandom;
            default: b = 32'h1 << $urandom_range(0, 31);
         endcase
         do_op(b, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      clr_n       = 1'b0;
      cpu.req     = 1'b0;
      cpu.bound   = '0;
      cpu.out_ack = 1'b0;
      rand_in     = '0;
      fork
         monitor();
         stimulus();
      join_any
      finish_run();
   end

endmodule
